shift_arbiter: RTL

- Shares one 32-bit barrel `shifter` between two requesters: the EX-stage shift path and an auxiliary unit.
- Arbitrates with round-robin or fixed priority and uses valid/ready handshakes on both sides.
- Selects the result by opcode and returns it through a one-entry registered response slot tagged with the requester ID.
- Sits beside the EX-stage ALU; throughput is one shift per cycle.

---
 rtl/shift_arbiter_pkg.sv | 37 +++
 rtl/shift_arbiter_shifter.sv | 42 ++++
 rtl/shift_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: opcode encodings, requester IDs,
// datapath widths and the opcode result-select helper.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    // Shift opcodes carried on req_op0 / req_op1
    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_SLL  = 2'b01;
    localparam logic [1:0] SH_SRL  = 2'b10;
    localparam logic [1:0] SH_SRA  = 2'b11;

    // Requester identifiers (EX-stage shift path and auxiliary unit)
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Pick one of the shifter's parallel results by opcode
    function automatic logic [DATA_W-1:0] sh_select(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] no_shift,
        input logic [DATA_W-1:0] logic_left,
        input logic [DATA_W-1:0] logic_right,
        input logic [DATA_W-1:0] arith_right
    );
        logic [DATA_W-1:0] res;
        case (op)
            SH_PASS: res = no_shift;
            SH_SLL:  res = logic_left;
            SH_SRL:  res = logic_right;
            SH_SRA:  res = arith_right;
            default: res = no_shift;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Shared 32-bit barrel shifter. Produces every shift flavour in parallel so
// the caller only needs a result mux; all outputs are exactly 32 bits with
// shifted-out bits discarded and sra replicating bit 31.
module shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] no_shift,
    output logic [DATA_W-1:0] logic_left,
    output logic [DATA_W-1:0] logic_right,
    output logic [DATA_W-1:0] arith_right
);

    logic [DATA_W-1:0] left_stage_s  [AMT_W+1];
    logic [DATA_W-1:0] right_stage_s [AMT_W+1];
    logic [DATA_W-1:0] arith_stage_s [AMT_W+1];

    // Log-depth barrel: stage k shifts by 2**k when amt[k] is set
    always_comb begin
        left_stage_s[0]  = data;
        right_stage_s[0] = data;
        arith_stage_s[0] = data;
        for (int k = 0; k < AMT_W; k++) begin
            if (amt[k]) begin
                left_stage_s[k+1]  = left_stage_s[k] << (1 << k);
                right_stage_s[k+1] = right_stage_s[k] >> (1 << k);
                arith_stage_s[k+1] = DATA_W'($signed(arith_stage_s[k]) >>> (1 << k));
            end else begin
                left_stage_s[k+1]  = left_stage_s[k];
                right_stage_s[k+1] = right_stage_s[k];
                arith_stage_s[k+1] = arith_stage_s[k];
            end
        end
    end

    assign no_shift    = data;
    assign logic_left  = left_stage_s[AMT_W];
    assign logic_right = right_stage_s[AMT_W];
    assign arith_right = arith_stage_s[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared barrel shifter. Round-robin
// (FAIR=1) or fixed priority to requester 0 (FAIR=0); the result is held in a
// one-entry registered response slot tagged with the issuing requester ID.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [AMT_W-1:0]  req_amt1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data
);

    logic              last_ptr_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [DATA_W-1:0] rsp_data_r;

    logic              slot_free_s;
    logic [1:0]        grant_s;
    logic              gnt_id_s;
    logic              accept_s;
    logic [1:0]        sel_op_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [AMT_W-1:0]  sel_amt_s;
    logic [DATA_W-1:0] no_shift_s;
    logic [DATA_W-1:0] logic_left_s;
    logic [DATA_W-1:0] logic_right_s;
    logic [DATA_W-1:0] arith_right_s;
    logic [DATA_W-1:0] result_s;

    // A new result may enter when the slot is empty or is being drained now
    assign slot_free_s = ~rsp_valid_r | rsp_ready;

    // Grant selection: a lone requester wins; ties go by policy
    always_comb begin
        grant_s = 2'b00;
        case (req_valid)
            2'b01: grant_s = 2'b01;
            2'b10: grant_s = 2'b10;
            2'b11: begin
                if (FAIR != 0) begin
                    if (last_ptr_r == REQ_ID1) begin
                        grant_s = 2'b01;
                    end else begin
                        grant_s = 2'b10;
                    end
                end else begin
                    grant_s = 2'b01;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    assign req_ready = grant_s & {2{slot_free_s}};
    assign accept_s  = |(req_valid & req_ready);
    assign gnt_id_s  = grant_s[1];

    // Steer the granted requester's payload into the shared shifter
    always_comb begin
        sel_op_s   = req_op0;
        sel_data_s = req_data0;
        sel_amt_s  = req_amt0;
        if (gnt_id_s == REQ_ID1) begin
            sel_op_s   = req_op1;
            sel_data_s = req_data1;
            sel_amt_s  = req_amt1;
        end else begin
            sel_op_s   = req_op0;
            sel_data_s = req_data0;
            sel_amt_s  = req_amt0;
        end
    end

    shifter u_shifter (
        .data        (sel_data_s),
        .amt         (sel_amt_s),
        .no_shift    (no_shift_s),
        .logic_left  (logic_left_s),
        .logic_right (logic_right_s),
        .arith_right (arith_right_s)
    );

    assign result_s = sh_select(sel_op_s, no_shift_s, logic_left_s,
                                logic_right_s, arith_right_s);

    // Response slot and round-robin pointer: load on accept, clear on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= REQ_ID0;
            rsp_data_r  <= {DATA_W{1'b0}};
            last_ptr_r  <= REQ_ID1;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= gnt_id_s;
            rsp_data_r  <= result_s;
            last_ptr_r  <= gnt_id_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule
